// File: rtl/trace_capture_unit_pkg.sv
// rtl/trace_capture_unit_pkg.sv - shared types and constants for the trace capture unit
package trace_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int DEPTH_DEF      = 16;
  localparam int MAX_CYCLES_DEF = 30;
  localparam int CYCW_DEF       = $clog2(MAX_CYCLES_DEF + 1);

  localparam logic MODE_ALL = 1'b0;
  localparam logic MODE_WB  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CYCW_DEF-1:0] cycle;
    logic [XLEN_DEF-1:0] pc;
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_capture_unit_if.sv
// rtl/trace_capture_unit_if.sv - trace drain stream between the tracer and its consumer
interface trace_capture_unit_if #(
  parameter int XLEN = 32,
  parameter int CYCW = 5
);
  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [CYCW-1:0] trace_cycle_o;
  logic [XLEN-1:0] trace_pc_o;
  logic [4:0]      trace_rd_o;
  logic [XLEN-1:0] trace_data_o;

  modport master (
    output trace_valid_o, trace_cycle_o, trace_pc_o, trace_rd_o, trace_data_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_valid_o, trace_cycle_o, trace_pc_o, trace_rd_o, trace_data_o,
    output trace_ready_i
  );
endinterface

// File: rtl/trace_capture_unit_fifo.sv
// rtl/trace_capture_unit_fifo.sv - synchronous FIFO with wrap-around pointers and occupancy count
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so a full FIFO still accepts on a pop cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/trace_capture_unit.sv
// rtl/trace_capture_unit.sv - cycle-windowed PC/writeback tracer with overflow accounting
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 30,
  parameter int CYCW       = $clog2(MAX_CYCLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 rd_we_i,
  input  logic [4:0]           rd_addr_i,
  input  logic [XLEN-1:0]      rd_data_i,
  trace_capture_unit_if.master trc,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [CYCW-1:0]      dropped_o
);
  typedef struct packed {
    logic [CYCW-1:0] cycle;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  state_t          state_q;
  logic            mode_q, busy_q, done_q, overflow_q;
  logic [CYCW-1:0] cyc_q, dropped_q;

  entry_t              wentry, hentry;
  logic                wb_hit, push_req, pop, full, empty, drop, last_pop;
  logic [$clog2(DEPTH):0] count;

  assign wb_hit   = rd_we_i && (rd_addr_i != 5'd0);
  assign push_req = (state_q == RUN) && ((mode_q == MODE_ALL) || wb_hit);
  assign pop      = !empty && trc.trace_ready_i;
  assign drop     = push_req && full && !pop;
  assign last_pop = pop && (count == ($clog2(DEPTH)+1)'(1));

  always_comb begin
    wentry       = '0;
    wentry.cycle = cyc_q;
    wentry.pc    = pc_i;
    wentry.rd    = wb_hit ? rd_addr_i : 5'd0;
    wentry.data  = wb_hit ? rd_data_i : '0;
  end

  trace_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (hentry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign trc.trace_valid_o = !empty;
  assign trc.trace_cycle_o = hentry.cycle;
  assign trc.trace_pc_o    = hentry.pc;
  assign trc.trace_rd_o    = hentry.rd;
  assign trc.trace_data_o  = hentry.data;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ALL;
      cyc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != '1) dropped_q <= dropped_q + 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= RUN;
            mode_q     <= mode_i;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        RUN: begin
          if (cyc_q == CYCW'(MAX_CYCLES - 1)) begin
            state_q <= DRAIN;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DRAIN: begin
          if (empty || last_pop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_capture_unit.sv
// tb/tb_trace_capture_unit.sv - scoreboard bench for trace_capture_unit
module tb_trace_capture_unit;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] pc = '0;
  logic        rd_we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic        busy, done, overflow;
  logic [4:0]  dropped;

  trace_capture_unit_if #(.XLEN(32), .CYCW(5)) tr();

  trace_capture_unit #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(30)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .mode_i     (mode),
    .pc_i       (pc),
    .rd_we_i    (rd_we),
    .rd_addr_i  (rd_addr),
    .rd_data_i  (rd_data),
    .trc        (tr),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (overflow),
    .dropped_o  (dropped)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  trace_entry_t exp_q[$];
  trace_entry_t held;
  bit           hold_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input int c, input int p, input int r, input int d);
    trace_entry_t e;
    e.cycle = 5'(c);
    e.pc    = 32'(p);
    e.rd    = 5'(r);
    e.data  = 32'(d);
    exp_q.push_back(e);
  endtask

  // rmode: 0 ready high, 1 ready low, 2 ready from stamp 16, 3 random
  // wpat:  0 no writes, 1 x0@3 and x5@5, 2 write on even stamps
  task automatic run_capture(input bit m, input int rmode, input int wpat);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      pc      = 32'(4 * k);
      rd_we   = 1'b0;
      rd_addr = 5'd9;
      rd_data = 32'hDEAD_0000 + 32'(k);
      if (wpat == 1 && k == 3) begin rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'd7;  end
      if (wpat == 1 && k == 5) begin rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'h2A; end
      if (wpat == 2 && (k % 2) == 0) begin
        rd_we = 1'b1; rd_addr = 5'(k + 1); rd_data = 32'(3 * k + 1);
      end
      case (rmode)
        0: tr.trace_ready_i = 1'b1;
        1: tr.trace_ready_i = 1'b0;
        2: tr.trace_ready_i = (k >= 16);
        default: tr.trace_ready_i = 1'($urandom_range(0, 1));
      endcase
      tick();
    end
    rd_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit rnd);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      tr.trace_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks head stability under backpressure.
  always @(negedge clk) begin
    if (!rst && tr.trace_valid_o) begin
      if (hold_valid) begin
        check("stable_cycle", 64'(tr.trace_cycle_o), 64'(held.cycle));
        check("stable_pc",    64'(tr.trace_pc_o),    64'(held.pc));
        check("stable_rd",    64'(tr.trace_rd_o),    64'(held.rd));
        check("stable_data",  64'(tr.trace_data_o),  64'(held.data));
      end
      if (tr.trace_ready_i) begin
        hold_valid = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_entry", 64'(tr.trace_cycle_o), 64'h1_0000);
        end else begin
          trace_entry_t e;
          e = exp_q.pop_front();
          check("entry_cycle", 64'(tr.trace_cycle_o), 64'(e.cycle));
          check("entry_pc",    64'(tr.trace_pc_o),    64'(e.pc));
          check("entry_rd",    64'(tr.trace_rd_o),    64'(e.rd));
          check("entry_data",  64'(tr.trace_data_o),  64'(e.data));
        end
      end else begin
        hold_valid    = 1'b1;
        held.cycle    = tr.trace_cycle_o;
        held.pc       = tr.trace_pc_o;
        held.rd       = tr.trace_rd_o;
        held.data     = tr.trace_data_o;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tr.trace_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",    64'(tr.trace_valid_o), 64'd0);
    check("rst_cycle",    64'(tr.trace_cycle_o), 64'd0);
    check("rst_pc",       64'(tr.trace_pc_o),    64'd0);
    check("rst_busy",     64'(busy),             64'd0);
    check("rst_done",     64'(done),             64'd0);
    check("rst_overflow", 64'(overflow),         64'd0);
    check("rst_dropped",  64'(dropped),          64'd0);
    rst = 1'b0;
    tick();

    // All-cycles capture, no backpressure
    for (int k = 0; k < 30; k++) expect_entry(k, 4 * k, 0, 0);
    run_capture(MODE_ALL, 0, 0);
    check("t1_busy_in_drain", 64'(busy), 64'd1);
    wait_done("t1", 1'b0);
    check("t1_overflow", 64'(overflow), 64'd0);
    check("t1_dropped",  64'(dropped),  64'd0);

    // Write-back filter: x0 write ignored, x5 write kept
    expect_entry(5, 20, 5, 42);
    run_capture(MODE_WB, 0, 1);
    wait_done("t2", 1'b0);

    // Overflow with ready held low through the window
    for (int k = 0; k < 16; k++) expect_entry(k, 4 * k, 0, 0);
    run_capture(MODE_ALL, 1, 0);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_dropped",  64'(dropped),  64'd14);
    check("t3_valid",    64'(tr.trace_valid_o), 64'd1);
    check("t3_done_early", 64'(done), 64'd0);
    wait_done("t3", 1'b0);
    check("t3_overflow_sticky", 64'(overflow), 64'd1);

    // Full FIFO with simultaneous pop: no drops
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) expect_entry(k, 4 * k, k + 1, 3 * k + 1);
      else            expect_entry(k, 4 * k, 0, 0);
    end
    run_capture(MODE_ALL, 2, 2);
    check("t4_overflow", 64'(overflow), 64'd0);
    check("t4_dropped",  64'(dropped),  64'd0);
    wait_done("t4", 1'b0);

    // Random backpressure, 15 filtered entries never exceed depth
    for (int k = 0; k < 30; k += 2) expect_entry(k, 4 * k, k + 1, 3 * k + 1);
    run_capture(MODE_WB, 3, 2);
    wait_done("t5", 1'b1);
    check("t5_overflow", 64'(overflow), 64'd0);

    // Asynchronous reset in the middle of a capture
    mode  = MODE_ALL;
    tr.trace_ready_i = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pc = 32'(4 * k);
      tick();
    end
    check("t6_pre_valid", 64'(tr.trace_valid_o), 64'd1);
    check("t6_pre_busy",  64'(busy),             64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(tr.trace_valid_o), 64'd0);
    check("t6_rst_busy",  64'(busy),             64'd0);
    check("t6_rst_done",  64'(done),             64'd0);
    check("t6_rst_cycle", 64'(tr.trace_cycle_o), 64'd0);
    check("t6_rst_pc",    64'(tr.trace_pc_o),    64'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 30; k++) expect_entry(k, 4 * k, 0, 0);
    run_capture(MODE_ALL, 0, 0);
    wait_done("t6", 1'b0);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_dropped",  64'(dropped),  64'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
